// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian 32-bit words from a
// counted byte stream, writes them from word address 0, and holds the datapath in reset until done.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned LIM_W   = CNT_W + 1;
    localparam logic [LIM_W-1:0] MAX_WORDS = LIM_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [1:0]          r_byte_idx;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [31:0]         r_word;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_cpu_reset;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic                w_xfer;
    logic [CNT_W-1:0]    w_count_full;
    logic                w_count_bad;
    logic                w_last_word;
    logic [31:0]         w_word_next;

    assign w_xfer       = in_valid && r_in_ready;
    assign w_count_full = {in_data, r_count[7:0]};
    assign w_count_bad  = (w_count_full == '0) || (LIM_W'(w_count_full) > MAX_WORDS);
    assign w_last_word  = (LIM_W'(r_word_idx) == (LIM_W'(r_count) - LIM_W'(1)));

    // Current word with the incoming byte dropped into its lane
    always_comb begin
        w_word_next = r_word;
        case (r_byte_idx)
            2'd0:    w_word_next[7:0]   = in_data;
            2'd1:    w_word_next[15:8]  = in_data;
            2'd2:    w_word_next[23:16] = in_data;
            default: w_word_next[31:24] = in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
            r_word      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LEN_LO;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_count[7:0] <= in_data;
                        r_state      <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_count[15:8] <= in_data;
                        r_byte_idx    <= '0;
                        r_word_idx    <= '0;
                        if (w_count_bad) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_word     <= w_word_next;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Fourth byte: issue the write in the following cycle
                        if (r_byte_idx == 2'd3) begin
                            r_state     <= S_WRITE;
                            r_in_ready  <= 1'b0;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_word_idx;
                            r_mem_wdata <= w_word_next;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last_word) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end else begin
                        r_state    <= S_DATA;
                        r_word_idx <= r_word_idx + ADDR_W'(1);
                        r_byte_idx <= '0;
                        r_in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state     <= S_LEN_LO;
                        r_in_ready  <= 1'b1;
                        r_done      <= 1'b0;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_ERR: begin
                    if (start) begin
                        r_state    <= S_LEN_LO;
                        r_in_ready <= 1'b1;
                        r_error    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule
